// File: rtl/bitstream_spi_loader.sv
// SPI-flash READ (0x03), byte-wise hunt for sync 0xFAB0FAB1, then header/data word framing until a desync header.
// Optional macro BITSTREAM_LOADER_AUTOSTART_EN issues one internal start pulse the second cycle after reset release.
module bitstream_spi_loader #(
   parameter int unsigned CLK_DIV        = 2,
   parameter logic [23:0] START_ADDR     = 24'h000000,
   parameter int unsigned NUM_ROWS       = 18,
   parameter int unsigned MAX_HUNT_BYTES = 1024
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   output logic        spi_sck_o,
   output logic        spi_cs_no,
   output logic        spi_mosi_o,
   input  logic        spi_miso_i,
   output logic [31:0] bitstream_data_o,
   output logic        bitstream_valid_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o
);
   localparam logic [31:0] SYNC_WORD = 32'hFAB0FAB1;
   localparam logic [31:0] CMD_WORD  = {8'h03, START_ADDR};
   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HUNT_W = $clog2(MAX_HUNT_BYTES + 1);
   localparam int ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [HUNT_W-1:0] HUNT_LAST = HUNT_W'(MAX_HUNT_BYTES - 1);
   localparam logic [ROW_W-1:0]  ROW_INIT  = ROW_W'(NUM_ROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_HUNT, S_HEADER, S_DATA, S_END
   } state_t;

   state_t              r_state;
   logic [DIV_W-1:0]    r_div;
   logic                r_sck;
   logic                r_cs_n;
   logic                r_mosi;
   logic [30:0]         r_cmd_sh;
   logic [4:0]          r_bit_cnt;
   logic [31:0]         r_shift;
   logic [HUNT_W-1:0]   r_hunt_cnt;
   logic [ROW_W-1:0]    r_row;
   logic [31:0]         r_data;
   logic                r_valid;
   logic                r_busy;
   logic                r_done;
   logic                r_err;

   logic                w_start;
   logic                w_spi_active;
   logic                w_tick;
   logic                w_rise;
   logic                w_fall;
   logic                w_byte_done;
   logic                w_word_done;
   logic [31:0]         w_shift_nxt;

`ifdef BITSTREAM_LOADER_AUTOSTART_EN
   logic [1:0] r_auto_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_auto_cnt <= 2'd0;
      end else if (r_auto_cnt != 2'd2) begin
         r_auto_cnt <= r_auto_cnt + 2'd1;
      end
   end

   assign w_start = start_i | (r_auto_cnt == 2'd1);
`else
   assign w_start = start_i;
`endif

   // SCK edges are decided one clk edge ahead, so MISO is sampled on the edge that raises SCK.
   assign w_spi_active = (r_state == S_CMD) || (r_state == S_HUNT) ||
                         (r_state == S_HEADER) || (r_state == S_DATA);
   assign w_tick       = (r_div == DIV_LAST);
   assign w_rise       = w_tick & ~r_sck;
   assign w_fall       = w_tick & r_sck;
   assign w_shift_nxt  = {r_shift[30:0], spi_miso_i};
   assign w_byte_done  = w_rise & (r_bit_cnt[2:0] == 3'd7);
   assign w_word_done  = w_rise & (r_bit_cnt == 5'd31);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_div      <= '0;
         r_sck      <= 1'b0;
         r_cs_n     <= 1'b1;
         r_mosi     <= 1'b0;
         r_cmd_sh   <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_hunt_cnt <= '0;
         r_row      <= '0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_spi_active) begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            if (w_tick) r_sck <= ~r_sck;
         end
         case (r_state)
            S_IDLE, S_END: begin
               r_cs_n <= 1'b1;
               r_sck  <= 1'b0;
               r_mosi <= 1'b0;
               // A start landing while CS is still being released is dropped.
               if (w_start && r_cs_n) begin
                  r_done     <= 1'b0;
                  r_err      <= 1'b0;
                  r_busy     <= 1'b1;
                  r_cs_n     <= 1'b0;
                  r_div      <= '0;
                  r_bit_cnt  <= '0;
                  r_hunt_cnt <= '0;
                  r_shift    <= '0;
                  r_mosi     <= CMD_WORD[31];
                  r_cmd_sh   <= CMD_WORD[30:0];
                  r_state    <= S_CMD;
               end
            end
            S_CMD: begin
               if (w_fall) begin
                  r_mosi    <= r_cmd_sh[30];
                  r_cmd_sh  <= {r_cmd_sh[29:0], 1'b0};
                  r_bit_cnt <= r_bit_cnt + 5'd1;
                  if (r_bit_cnt == 5'd31) begin
                     r_mosi    <= 1'b0;
                     r_bit_cnt <= '0;
                     r_state   <= S_HUNT;
                  end
               end
            end
            S_HUNT: begin
               if (w_rise) begin
                  r_shift   <= w_shift_nxt;
                  r_bit_cnt <= r_bit_cnt + 5'd1;
                  if (w_byte_done) begin
                     if (w_shift_nxt == SYNC_WORD) begin
                        r_data    <= w_shift_nxt;
                        r_valid   <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= S_HEADER;
                     end else if (r_hunt_cnt == HUNT_LAST) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_END;
                     end else begin
                        r_hunt_cnt <= r_hunt_cnt + HUNT_W'(1);
                     end
                  end
               end
            end
            S_HEADER: begin
               if (w_rise) begin
                  r_shift   <= w_shift_nxt;
                  r_bit_cnt <= r_bit_cnt + 5'd1;
                  if (w_word_done) begin
                     r_data  <= w_shift_nxt;
                     r_valid <= 1'b1;
                     if (w_shift_nxt[20]) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_END;
                     end else begin
                        r_row   <= ROW_INIT;
                        r_state <= S_DATA;
                     end
                  end
               end
            end
            S_DATA: begin
               if (w_rise) begin
                  r_shift   <= w_shift_nxt;
                  r_bit_cnt <= r_bit_cnt + 5'd1;
                  if (w_word_done) begin
                     r_data  <= w_shift_nxt;
                     r_valid <= 1'b1;
                     if (r_row == '0) r_state <= S_HEADER;
                     else r_row <= r_row - ROW_W'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign spi_sck_o         = r_sck;
   assign spi_cs_no         = r_cs_n;
   assign spi_mosi_o        = r_mosi;
   assign bitstream_data_o  = r_data;
   assign bitstream_valid_o = r_valid;
   assign busy_o            = r_busy;
   assign done_o            = r_done;
   assign error_o           = r_err;
endmodule

// File: tb/tb_bitstream_spi_loader.sv
// Bench for bitstream_spi_loader: behavioural SPI flash plus a word scoreboard fed when the flash image is written.
module tb_bitstream_spi_loader;
   localparam int CLK_DIV = 3;
   localparam logic [23:0] START_ADDR = 24'h123456;
   localparam int NUM_ROWS = 18;
   localparam int MAX_HUNT = 16;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic        spi_miso_i = 1'b0;
   logic        spi_sck_o, spi_cs_no, spi_mosi_o;
   logic [31:0] bitstream_data_o;
   logic        bitstream_valid_o, busy_o, done_o, error_o;

   always #5 clk_i = ~clk_i;

   bitstream_spi_loader #(
      .CLK_DIV(CLK_DIV), .START_ADDR(START_ADDR),
      .NUM_ROWS(NUM_ROWS), .MAX_HUNT_BYTES(MAX_HUNT)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
      .spi_sck_o(spi_sck_o), .spi_cs_no(spi_cs_no), .spi_mosi_o(spi_mosi_o),
      .spi_miso_i(spi_miso_i), .bitstream_data_o(bitstream_data_o),
      .bitstream_valid_o(bitstream_valid_o), .busy_o(busy_o),
      .done_o(done_o), .error_o(error_o)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [7:0]  mem [256];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Flash: mode 0, captures 32 command bits on SCK rise, shifts data out on SCK fall.
   int          f_cnt = 0;
   int          f_obit = 0;
   int          f_rises = 0;
   logic [31:0] f_cmd = '0;
   logic [23:0] f_addr;
   logic [7:0]  f_byte;
   always @(posedge spi_cs_no or posedge spi_sck_o or negedge spi_sck_o) begin
      if (spi_cs_no) begin
         f_cnt  = 0;
         f_obit = 0;
      end else if (spi_sck_o) begin
         if (f_cnt < 32) begin
            f_cmd = {f_cmd[30:0], spi_mosi_o};
            f_cnt++;
            if (f_cnt == 32) f_rises = 0;
         end else begin
            f_rises++;
         end
      end else if (f_cnt == 32) begin
         f_addr = f_cmd[23:0] + 24'(f_obit / 8);
         f_byte = mem[f_addr[7:0]];
         spi_miso_i = f_byte[7 - (f_obit % 8)];
         f_obit++;
      end
   end

   int   cyc = 0, n_valid = 0, last_vcyc = 0, since = 0;
   bit   first_word = 1'b1;
   logic prev_sck = 1'b0, prev_cs = 1'b1;
   always @(negedge clk_i) begin
      cyc++;
      since++;
      if (bitstream_valid_o) begin
         n_valid++;
         check_val("word_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) check_val("word_data", 64'(bitstream_data_o), 64'(exp_q.pop_front()));
         if (!first_word) check_val("valid_spacing", 64'(cyc - last_vcyc), 64'(CLK_DIV * 64));
         first_word = 1'b0;
         last_vcyc  = cyc;
      end
      if (!busy_o) first_word = 1'b1;
      if (prev_cs && !spi_cs_no) since = 0;
      else if (!spi_cs_no && spi_sck_o != prev_sck) begin
         check_val("sck_half_period", 64'(since), 64'(CLK_DIV));
         since = 0;
      end
      prev_cs  = spi_cs_no;
      prev_sck = spi_sck_o;
   end

   task automatic fill_ff();
      for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
   endtask

   // Image at the flash read address: two junk bytes, sync, header, NUM_ROWS words, desync header.
   task automatic load_stream();
      logic [31:0] w;
      int p;
      fill_ff();
      p = int'(START_ADDR[7:0]);
      mem[p & 255] = 8'h12;
      mem[(p + 1) & 255] = 8'h34;
      p += 2;
      for (int k = 0; k < NUM_ROWS + 3; k++) begin
         if (k == 0) w = 32'hFAB0FAB1;
         else if (k == 1) w = 32'h00000001;
         else if (k == NUM_ROWS + 2) w = 32'h00100000;
         else w = $urandom;
         for (int b = 0; b < 4; b++) begin
            mem[p & 255] = w[31 - 8 * b -: 8];
            p++;
         end
         exp_q.push_back(w);
      end
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic wait_valids(input string tag, input int target, input int max);
      int n = 0;
      while (n_valid < target && n < max) begin
         @(negedge clk_i);
         n++;
      end
      check_val(tag, 64'(n_valid >= target), 64'd1);
   endtask

   task automatic wait_end(input string tag, input int max);
      int n = 0;
      while (!(done_o || error_o) && n < max) begin
         @(negedge clk_i);
         n++;
      end
      check_val(tag, 64'(done_o || error_o), 64'd1);
   endtask

   int base;

   initial begin
      repeat (3) @(negedge clk_i);
      check_val("rst_cs", 64'(spi_cs_no), 64'd1);
      check_val("rst_sck", 64'(spi_sck_o), 64'd0);
      check_val("rst_mosi", 64'(spi_mosi_o), 64'd0);
      check_val("rst_data", 64'(bitstream_data_o), 64'd0);
      check_val("rst_valid", 64'(bitstream_valid_o), 64'd0);
      check_val("rst_busy", 64'(busy_o), 64'd0);
      check_val("rst_done", 64'(done_o), 64'd0);
      check_val("rst_error", 64'(error_o), 64'd0);
      rst_ni = 1'b1;
      repeat (3) @(negedge clk_i);
      check_val("idle_cs", 64'(spi_cs_no), 64'd1);

      // Full load with leading junk; a second start mid-stream must change nothing.
      load_stream();
      base = n_valid;
      pulse_start();
      check_val("start_cs_low", 64'(spi_cs_no), 64'd0);
      check_val("start_busy", 64'(busy_o), 64'd1);
      wait_valids("run1_first_words", base + 3, 5000);
      pulse_start();
      check_val("busy_after_restart", 64'(busy_o), 64'd1);
      wait_end("run1_end", 20000);
      @(negedge clk_i);
      check_val("run1_words", 64'(n_valid - base), 64'(NUM_ROWS + 3));
      check_val("run1_queue_left", 64'(exp_q.size()), 64'd0);
      check_val("run1_done", 64'(done_o), 64'd1);
      check_val("run1_error", 64'(error_o), 64'd0);
      check_val("run1_busy", 64'(busy_o), 64'd0);
      check_val("run1_cs_high", 64'(spi_cs_no), 64'd1);
      check_val("run1_sck_low", 64'(spi_sck_o), 64'd0);
      check_val("mosi_cmd", 64'(f_cmd), 64'h03123456);

      // Reset while streaming data words, then a clean reload.
      load_stream();
      base = n_valid;
      pulse_start();
      check_val("run2_done_cleared", 64'(done_o), 64'd0);
      wait_valids("run2_mid_words", base + 8, 5000);
      #2 rst_ni = 1'b0;
      #1;
      check_val("arst_cs", 64'(spi_cs_no), 64'd1);
      check_val("arst_sck", 64'(spi_sck_o), 64'd0);
      check_val("arst_valid", 64'(bitstream_valid_o), 64'd0);
      check_val("arst_busy", 64'(busy_o), 64'd0);
      check_val("arst_data", 64'(bitstream_data_o), 64'd0);
      exp_q.delete();
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk_i);
      load_stream();
      base = n_valid;
      pulse_start();
      wait_end("run2_end", 20000);
      @(negedge clk_i);
      check_val("run2_words", 64'(n_valid - base), 64'(NUM_ROWS + 3));
      check_val("run2_queue_left", 64'(exp_q.size()), 64'd0);
      check_val("run2_done", 64'(done_o), 64'd1);

      // Flash without a sync word: hunt gives up after MAX_HUNT bytes.
      fill_ff();
      base = n_valid;
      pulse_start();
      check_val("run3_done_cleared", 64'(done_o), 64'd0);
      check_val("run3_busy", 64'(busy_o), 64'd1);
      wait_end("run3_end", 8000);
      @(negedge clk_i);
      check_val("run3_error", 64'(error_o), 64'd1);
      check_val("run3_done", 64'(done_o), 64'd0);
      check_val("run3_busy_end", 64'(busy_o), 64'd0);
      check_val("run3_no_words", 64'(n_valid - base), 64'd0);
      check_val("run3_bits_read", 64'(f_rises), 64'(MAX_HUNT * 8));
      check_val("run3_cs_high", 64'(spi_cs_no), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
